// File: rtl/pll_drp_pkg.sv
// rtl/pll_drp_pkg.sv - shared types and DRP constants for the PLL reconfiguration sequencer
package pll_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRST,
    S_RD,
    S_WRD,
    S_WR,
    S_WWR,
    S_NXT,
    S_REL,
    S_WLK,
    S_FIN
  } state_e;

  localparam int AddrW  = 7;
  localparam int DataW  = 16;
  localparam int EntryW = AddrW + 2 * DataW;

  localparam logic [AddrW-1:0] ClkReg1 = 7'h08;
  localparam logic [AddrW-1:0] ClkReg2 = 7'h09;
  localparam logic [AddrW-1:0] FbReg1  = 7'h14;
  localparam logic [AddrW-1:0] FbReg2  = 7'h15;

endpackage

// File: rtl/pll_drp_rom.sv
// rtl/pll_drp_rom.sv - profile table: (profile, idx) -> {addr, keep mask, set data}
module pll_drp_rom
  import pll_drp_pkg::*;
#(
  parameter int PROF_W = 1,
  parameter int IDX_W  = 2
) (
  input  logic [PROF_W-1:0] profile,
  input  logic [IDX_W-1:0]  idx,
  output logic [EntryW-1:0] entry
);

  logic fast;
  assign fast = (int'(profile) == 1);

  // VCO = 1600 MHz from 100 MHz; CLKOUT0 divides by 64 (25 MHz) or 32 (50 MHz)
  always_comb begin
    entry = '0;
    case (int'(idx))
      0:       entry = {ClkReg1, 16'h1000, fast ? 16'h0410 : 16'h0820};
      1:       entry = {ClkReg2, 16'h8000, 16'h0000};
      2:       entry = {FbReg1,  16'h1000, 16'h0208};
      3:       entry = {FbReg2,  16'h8000, 16'h0000};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/pll_drp_seq.sv
// rtl/pll_drp_seq.sv - runtime PLLE2 reconfiguration over DRP, owns PLL and core reset
module pll_drp_seq
  import pll_drp_pkg::*;
#(
  parameter int NUM_PROFILES = 2,
  parameter int NUM_REGS     = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int PROF_W       = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [PROF_W-1:0] i_profile,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [6:0]        o_daddr,
  output logic [15:0]       o_di,
  output logic              o_den,
  output logic              o_dwe,
  input  logic [15:0]       i_do,
  input  logic              i_drdy,
  input  logic              i_locked,
  output logic              o_pll_rst,
  output logic              o_rst_core
);

  localparam int IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [15:0] DrdyLim = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LockLim = 16'(LOCK_TIMEOUT - 1);

  state_e            state;
  logic [IdxW-1:0]   idx;
  logic [PROF_W-1:0] prof_q;
  logic              err;
  logic [15:0]       rdat;
  logic [15:0]       cnt;
  logic              lk_meta, lk_s, lk_seen;
  logic [EntryW-1:0] entry;
  logic [6:0]        e_addr;
  logic [15:0]       e_mask, e_data;

  pll_drp_rom #(.PROF_W(PROF_W), .IDX_W(IdxW)) u_rom (
    .profile (prof_q),
    .idx     (idx),
    .entry   (entry)
  );

  assign {e_addr, e_mask, e_data} = entry;

  // cnt saturates by default; every transition below overrides it with 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      prof_q     <= '0;
      err        <= 1'b0;
      rdat       <= '0;
      cnt        <= '0;
      lk_meta    <= 1'b0;
      lk_s       <= 1'b0;
      lk_seen    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_daddr    <= '0;
      o_di       <= '0;
      o_den      <= 1'b0;
      o_dwe      <= 1'b0;
      o_pll_rst  <= 1'b0;
      o_rst_core <= 1'b1;
    end else begin
      lk_meta    <= i_locked;
      lk_s       <= lk_meta;
      o_rst_core <= o_busy | ~lk_s;
      o_den      <= 1'b0;
      o_dwe      <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      case (state)
        S_IDLE: if (i_req) begin
          prof_q <= i_profile;
          o_busy <= 1'b1;
          cnt    <= '0;
          if (int'(i_profile) >= NUM_PROFILES) begin
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            err   <= 1'b0;
            state <= S_PRST;
          end
        end
        S_PRST: begin
          o_pll_rst <= 1'b1;
          idx       <= '0;
          cnt       <= '0;
          state     <= S_RD;
        end
        S_RD: begin
          o_den   <= 1'b1;
          o_daddr <= e_addr;
          cnt     <= '0;
          state   <= S_WRD;
        end
        S_WRD: if (i_drdy) begin
          rdat  <= i_do;
          cnt   <= '0;
          state <= S_WR;
        end else if (cnt >= DrdyLim) begin
          err   <= 1'b1;
          cnt   <= '0;
          state <= S_REL;
        end
        S_WR: begin
          o_den   <= 1'b1;
          o_dwe   <= 1'b1;
          o_daddr <= e_addr;
          o_di    <= (rdat & e_mask) | e_data;
          cnt     <= '0;
          state   <= S_WWR;
        end
        S_WWR: if (i_drdy) begin
          cnt   <= '0;
          state <= S_NXT;
        end else if (cnt >= DrdyLim) begin
          err   <= 1'b1;
          cnt   <= '0;
          state <= S_REL;
        end
        S_NXT: begin
          cnt <= '0;
          if (idx == IdxW'(NUM_REGS - 1)) begin
            state <= S_REL;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_RD;
          end
        end
        S_REL: begin
          o_pll_rst <= 1'b0;
          lk_seen   <= 1'b0;
          cnt       <= '0;
          state     <= S_WLK;
        end
        S_WLK: begin
          lk_seen <= lk_s;
          if (lk_s && lk_seen) begin
            cnt   <= '0;
            state <= S_FIN;
          end else if (cnt >= LockLim) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          o_done <= 1'b1;
          o_err  <= err;
          o_busy <= 1'b0;
          cnt    <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
